owire_responder: RTL and testbench

- Responder end of a single-wire, half-duplex, tri-stated serial link.
- Listens on a shared inout line for a request byte from the initiator.
- After a fixed turnaround, takes ownership of the line and drives back a one-byte reply, then releases it (high-Z).
- Sits between a board-level bidirectional pin and local logic that consumes requests and supplies replies.

---
 rtl/owire_responder_if.sv | 29 ++
 rtl/owire_responder.sv | 258 +++++++++++++++++++++++++
 tb/tb_owire_responder.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/owire_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : owire_responder_if
// Description : Local-side bundle of the single-wire responder: reply byte
//               in, received request byte and status pulses out.
// Revision    : 1.0 - initial release
// ============================================================================
interface owire_responder_if;
  logic [7:0] rsp_data;
  logic       rsp_valid;
  logic [7:0] req_data;
  logic       req_valid;
  logic       frame_err;
  logic       busy;
  logic       drive_en;

  // Local logic: supplies replies, consumes requests and status.
  modport master (
    output rsp_data, rsp_valid,
    input  req_data, req_valid, frame_err, busy, drive_en
  );

  // Responder block.
  modport slave (
    input  rsp_data, rsp_valid,
    output req_data, req_valid, frame_err, busy, drive_en
  );
endinterface
`default_nettype wire

// File: rtl/owire_responder.sv
`default_nettype none
// ============================================================================
// Module      : owire_responder
// Description : Responder end of a half-duplex single-wire serial link.
//               Receives a request byte on the shared line, waits a fixed
//               turnaround, then drives a one-byte reply and releases the
//               line. Frame: start(0), 8 data LSB first, [parity], stop(1).
//               Optional even-parity bit enabled by OWIRE_RESPONDER_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module owire_responder #(
  parameter int BIT_CYCLES  = 16,
  parameter int TURN_CYCLES = 2
) (
  input  wire logic        clk,
  input  wire logic        rst,
  inout  wire              line,
  owire_responder_if.slave bus
);

  localparam int             CW        = $clog2(BIT_CYCLES * TURN_CYCLES) + 1;
  localparam logic [CW-1:0]  CNT_MAX   = {CW{1'b1}};
  localparam logic [CW-1:0]  HALF_LAST = CW'(BIT_CYCLES / 2 - 1);
  localparam logic [CW-1:0]  BIT_LAST  = CW'(BIT_CYCLES - 1);
  // Turnaround runs from the stop-bit mid-sample to the end of the idle bits.
  localparam logic [CW-1:0]  TURN_LAST = CW'(BIT_CYCLES / 2 + TURN_CYCLES * BIT_CYCLES - 1);
  localparam logic [7:0]     NAK       = 8'h15;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    RX_START = 4'd1,
    RX_DATA  = 4'd2,
    RX_STOP  = 4'd3,
    TURN     = 4'd4,
    TX_START = 4'd5,
    TX_DATA  = 4'd6,
    TX_STOP  = 4'd7
`ifdef OWIRE_RESPONDER_PARITY_EN
    ,
    RX_PAR   = 4'd8,
    TX_PAR   = 4'd9
`endif
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shreg, shreg_n;
  logic [7:0]    txb, txb_n;
  logic          tx_bit, tx_bit_n;
  logic          drive_r, drive_n;
  logic [7:0]    req_data_r, req_data_n;
  logic          req_valid_r, req_valid_n;
  logic          frame_err_r, frame_err_n;
  logic          sync1, line_s, line_s_d;
  logic          rx_bad;
  logic [7:0]    tx_byte;

`ifdef OWIRE_RESPONDER_PARITY_EN
  logic          par_bad, par_bad_n;
  logic          tx_par, tx_par_n;
  assign rx_bad = par_bad;
`else
  assign rx_bad = 1'b0;
`endif

  // Reply byte chosen at the end of the turnaround; NAK when none is offered.
  assign tx_byte = bus.rsp_valid ? bus.rsp_data : NAK;

  // Tri-state pin driver: only drive while replying.
  assign line = drive_r ? tx_bit : 1'bz;

  assign bus.req_data  = req_data_r;
  assign bus.req_valid = req_valid_r;
  assign bus.frame_err = frame_err_r;
  assign bus.drive_en  = drive_r;
  assign bus.busy      = (state != IDLE);

  // Two-flop synchronizer plus one delay stage for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1    <= 1'b1;
      line_s   <= 1'b1;
      line_s_d <= 1'b1;
    end else begin
      sync1    <= line;
      line_s   <= sync1;
      line_s_d <= line_s;
    end
  end

  // State and datapath registers; reset releases the line immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= 3'd0;
      shreg       <= 8'h00;
      txb         <= 8'h00;
      tx_bit      <= 1'b1;
      drive_r     <= 1'b0;
      req_data_r  <= 8'h00;
      req_valid_r <= 1'b0;
      frame_err_r <= 1'b0;
`ifdef OWIRE_RESPONDER_PARITY_EN
      par_bad     <= 1'b0;
      tx_par      <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      bit_idx     <= bit_n;
      shreg       <= shreg_n;
      txb         <= txb_n;
      tx_bit      <= tx_bit_n;
      drive_r     <= drive_n;
      req_data_r  <= req_data_n;
      req_valid_r <= req_valid_n;
      frame_err_r <= frame_err_n;
`ifdef OWIRE_RESPONDER_PARITY_EN
      par_bad     <= par_bad_n;
      tx_par      <= tx_par_n;
`endif
    end
  end

  // Next-state and datapath logic; the bit timer saturates rather than wraps.
  always_comb begin
    state_n     = state;
    cnt_n       = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
    bit_n       = bit_idx;
    shreg_n     = shreg;
    txb_n       = txb;
    tx_bit_n    = tx_bit;
    drive_n     = drive_r;
    req_data_n  = req_data_r;
    req_valid_n = 1'b0;
    frame_err_n = 1'b0;
`ifdef OWIRE_RESPONDER_PARITY_EN
    par_bad_n   = par_bad;
    tx_par_n    = tx_par;
`endif
    case (state)
      IDLE: begin
        if (line_s_d && !line_s) begin
          state_n = RX_START;
          cnt_n   = '0;
          bit_n   = 3'd0;
        end
      end
      RX_START: begin
        // Half-bit check rejects glitches and re-centres the timer on mid-bit.
        if (cnt == HALF_LAST) begin
          cnt_n   = '0;
          bit_n   = 3'd0;
          state_n = line_s ? IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          shreg_n = {line_s, shreg[7:1]};
          bit_n   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef OWIRE_RESPONDER_PARITY_EN
            state_n = RX_PAR;
`else
            state_n = RX_STOP;
`endif
          end
        end
      end
`ifdef OWIRE_RESPONDER_PARITY_EN
      RX_PAR: begin
        if (cnt == BIT_LAST) begin
          cnt_n     = '0;
          par_bad_n = line_s ^ (^shreg);
          state_n   = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (line_s && !rx_bad) begin
            req_data_n  = shreg;
            req_valid_n = 1'b1;
            state_n     = TURN;
          end else begin
            frame_err_n = 1'b1;
            state_n     = IDLE;
          end
        end
      end
      TURN: begin
        if (cnt == TURN_LAST) begin
          cnt_n    = '0;
          txb_n    = tx_byte;
          tx_bit_n = 1'b0;
          drive_n  = 1'b1;
          state_n  = TX_START;
`ifdef OWIRE_RESPONDER_PARITY_EN
          tx_par_n = ^tx_byte;
`endif
        end
      end
      TX_START: begin
        if (cnt == BIT_LAST) begin
          cnt_n    = '0;
          bit_n    = 3'd0;
          tx_bit_n = txb[0];
          txb_n    = {1'b0, txb[7:1]};
          state_n  = TX_DATA;
        end
      end
      TX_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          bit_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef OWIRE_RESPONDER_PARITY_EN
            tx_bit_n = tx_par;
            state_n  = TX_PAR;
`else
            tx_bit_n = 1'b1;
            state_n  = TX_STOP;
`endif
          end else begin
            tx_bit_n = txb[0];
            txb_n    = {1'b0, txb[7:1]};
          end
        end
      end
`ifdef OWIRE_RESPONDER_PARITY_EN
      TX_PAR: begin
        if (cnt == BIT_LAST) begin
          cnt_n    = '0;
          tx_bit_n = 1'b1;
          state_n  = TX_STOP;
        end
      end
`endif
      TX_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          drive_n = 1'b0;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        drive_n = 1'b0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_owire_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_owire_responder
// Description : Scoreboard bench for owire_responder. Stimulus pushes the
//               expected request/error events and reply frames into queues;
//               a negedge monitor pops and compares them as the DUT responds.
//               Parity cases run when OWIRE_RESPONDER_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_owire_responder;

  localparam int BIT      = 16;
  localparam int TURN     = 2;
  localparam int HALF     = BIT / 2;
  localparam int TURN_GAP = HALF + TURN * BIT;
`ifdef OWIRE_RESPONDER_PARITY_EN
  localparam int FBITS = 11;
`else
  localparam int FBITS = 10;
`endif

  logic clk = 1'b0;
  logic rst;
  logic host_oe;
  wire  line;

  pullup (line);
  assign line = host_oe ? 1'b0 : 1'bz;

  owire_responder_if bus_if ();

  owire_responder #(.BIT_CYCLES(BIT), .TURN_CYCLES(TURN)) dut (
    .clk  (clk),
    .rst  (rst),
    .line (line),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct { bit is_err; logic [7:0] data; } ev_t;
  typedef struct { logic [7:0] data; bit abort; } rp_t;
  ev_t ev_q[$];
  rp_t rp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame bits, index 0 first on the wire.
  function automatic logic [10:0] frame_of(input logic [7:0] d, input bit par_ok, input bit stop);
    logic [10:0] f;
    f      = '0;
    f[0]   = 1'b0;
    f[8:1] = d;
`ifdef OWIRE_RESPONDER_PARITY_EN
    f[9]   = (^d) ^ !par_ok;
    f[10]  = stop;
`else
    f[9]   = stop;
`endif
    return f;
  endfunction

  task automatic send_req(input logic [7:0] d, input bit par_ok, input bit stop);
    logic [10:0] f;
    f = frame_of(d, par_ok, stop);
    @(negedge clk);
    for (int i = 0; i < FBITS; i++) begin
      host_oe = ~f[i];
      repeat (BIT) @(negedge clk);
    end
    host_oe = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (!bus_if.busy && !bus_if.drive_en) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL wait_idle: timed out after %0d cycles", max_cycles);
  endtask

  // ---------------- monitor / scoreboard ----------------
  int          cyc = 0;
  int          last_req_cyc = -100000;
  bit          prev_rv, prev_fe, prev_de;
  int          rv_w, fe_w;
  bit          rm_active;
  int          rm_cnt;
  logic [10:0] rm_bits;
  rp_t         rm_exp;
  ev_t         ev;

  always @(negedge clk) begin
    if (rst) begin
      if (rm_active) begin
        check("reply_abort_expected", 32'(rm_exp.abort), 32'd1);
        rm_active = 1'b0;
      end
      prev_rv = 1'b0; prev_fe = 1'b0; prev_de = 1'b0;
      rv_w = 0; fe_w = 0;
    end else begin
      if (bus_if.req_valid && !prev_rv) begin
        last_req_cyc = cyc;
        if (ev_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_req_valid: got req_data %0h expected no event", bus_if.req_data);
        end else begin
          ev = ev_q.pop_front();
          check("event_kind_req", 32'd0, 32'(ev.is_err));
          check("req_data", 32'(bus_if.req_data), 32'(ev.data));
        end
      end
      if (bus_if.frame_err && !prev_fe) begin
        if (ev_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_frame_err: got 1 expected 0");
        end else begin
          ev = ev_q.pop_front();
          check("event_kind_err", 32'd1, 32'(ev.is_err));
        end
      end
      if (bus_if.req_valid) rv_w++;
      else if (prev_rv) begin check("req_valid_width", 32'(rv_w), 32'd1); rv_w = 0; end
      if (bus_if.frame_err) fe_w++;
      else if (prev_fe) begin check("frame_err_width", 32'(fe_w), 32'd1); fe_w = 0; end

      if (bus_if.drive_en && !prev_de) begin
        if (rp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_drive_en: got 1 expected 0");
        end else begin
          rm_exp    = rp_q.pop_front();
          rm_active = 1'b1;
          rm_cnt    = 0;
          rm_bits   = '0;
          check("turnaround_cycles", 32'(cyc - last_req_cyc), 32'(TURN_GAP));
        end
      end
      if (rm_active) begin
        if (bus_if.drive_en) begin
          if ((rm_cnt % BIT) == HALF && (rm_cnt / BIT) < FBITS) rm_bits[rm_cnt / BIT] = line;
          rm_cnt++;
        end else begin
          check("reply_completed_unaborted", 32'(rm_exp.abort), 32'd0);
          check("drive_en_cycles", 32'(rm_cnt), 32'(FBITS * BIT));
          check("reply_frame", 32'(rm_bits), 32'(frame_of(rm_exp.data, 1'b1, 1'b1)));
          rm_active = 1'b0;
        end
      end
      prev_rv = bus_if.req_valid;
      prev_fe = bus_if.frame_err;
      prev_de = bus_if.drive_en;
    end
    cyc++;
  end

  // Hard stop if something hangs.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int bc;
    bit seen;
    rst               = 1'b1;
    host_oe           = 1'b0;
    bus_if.rsp_data   = 8'h00;
    bus_if.rsp_valid  = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_req_data",  32'(bus_if.req_data), 32'h00);
    check("rst_req_valid", 32'(bus_if.req_valid), 32'd0);
    check("rst_frame_err", 32'(bus_if.frame_err), 32'd0);
    check("rst_busy",      32'(bus_if.busy), 32'd0);
    check("rst_drive_en",  32'(bus_if.drive_en), 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Request A5, reply 3C.
    bus_if.rsp_valid = 1'b1;
    bus_if.rsp_data  = 8'h3C;
    ev_q.push_back('{1'b0, 8'hA5});
    rp_q.push_back('{8'h3C, 1'b0});
    send_req(8'hA5, 1'b1, 1'b1);
    wait_idle(600);
    repeat (10) @(negedge clk);

    // Same request, no reply offered: NAK.
    bus_if.rsp_valid = 1'b0;
    ev_q.push_back('{1'b0, 8'hA5});
    rp_q.push_back('{8'h15, 1'b0});
    send_req(8'hA5, 1'b1, 1'b1);
    wait_idle(600);
    check("req_data_after_nak", 32'(bus_if.req_data), 32'hA5);
    repeat (10) @(negedge clk);

    // Three-cycle low glitch on the idle line.
    host_oe = 1'b1;
    repeat (3) @(negedge clk);
    host_oe = 1'b0;
    bc = 0;
    repeat (40) @(negedge clk) if (bus_if.busy) bc++;
    check("glitch_busy_seen", 32'(bc >= 1), 32'd1);
    check("glitch_busy_bounded", 32'(bc <= HALF + 3), 32'd1);
    check("glitch_idle_after", 32'(bus_if.busy), 32'd0);

    // Request 5A with stop bit forced low.
    bus_if.rsp_valid = 1'b1;
    ev_q.push_back('{1'b1, 8'h00});
    send_req(8'h5A, 1'b1, 1'b0);
    wait_idle(200);
    repeat (60) @(negedge clk);
    check("req_data_hold_after_err", 32'(bus_if.req_data), 32'hA5);

    // Reset in the middle of the fourth data bit of a reply.
    bus_if.rsp_data = 8'h3C;
    ev_q.push_back('{1'b0, 8'hC3});
    rp_q.push_back('{8'h3C, 1'b1});
    send_req(8'hC3, 1'b1, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (bus_if.drive_en) seen = 1'b1;
    end
    check("reply_started_before_reset", 32'(seen), 32'd1);
    repeat (4 * BIT + HALF) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_drive_en", 32'(bus_if.drive_en), 32'd0);
    check("async_rst_line_released", 32'(line), 32'd1);
    check("async_rst_busy", 32'(bus_if.busy), 32'd0);
    check("async_rst_req_data", 32'(bus_if.req_data), 32'h00);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Next request handled normally.
    bus_if.rsp_data = 8'h81;
    ev_q.push_back('{1'b0, 8'h01});
    rp_q.push_back('{8'h81, 1'b0});
    send_req(8'h01, 1'b1, 1'b1);
    wait_idle(600);
    repeat (10) @(negedge clk);

`ifdef OWIRE_RESPONDER_PARITY_EN
    // Wrong parity: error, no reply.
    ev_q.push_back('{1'b1, 8'h00});
    send_req(8'h07, 1'b0, 1'b1);
    wait_idle(200);
    repeat (60) @(negedge clk);
    // Correct parity: request accepted, reply carries even parity.
    bus_if.rsp_data = 8'hC1;
    ev_q.push_back('{1'b0, 8'h07});
    rp_q.push_back('{8'hC1, 1'b0});
    send_req(8'h07, 1'b1, 1'b1);
    wait_idle(600);
    repeat (10) @(negedge clk);
`endif

    repeat (20) @(negedge clk);
    check("event_queue_drained", 32'(ev_q.size()), 32'd0);
    check("reply_queue_drained", 32'(rp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
